// File: rtl/sched_pkg.sv
// Shared types and frame layout for the frame scheduler.
// Latency: none (types, constants and one pure function).
// Backpressure: not applicable.
package sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    SHIFT  = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam logic [3:0] BTN_TAG_DEF = 4'hB;
  localparam logic [3:0] HB_TAG_DEF  = 4'h5;

  // Frame layout: tag nibble on top, rolling sequence number below.
  localparam int TAG_MSB = 7;
  localparam int TAG_LSB = 4;
  localparam int SEQ_W   = 4;

  function automatic logic [7:0] make_frame(input logic [3:0] tag,
                                            input logic [SEQ_W-1:0] seq);
    logic [7:0] frame;
    frame                  = 8'h00;
    frame[TAG_MSB:TAG_LSB] = tag;
    frame[SEQ_W-1:0]       = seq;
    return frame;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, debounce counter, press pulse.
// Latency: press pulses DEBOUNCE_CYCLES+2 cycles after a clean falling edge.
// Backpressure: none; press is a one-cycle pulse that must be consumed.
// Ports: clk, rst (async active-high), bbutton (raw, active-low),
//        press (one-cycle pulse on accepted 1->0 of the debounced level).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst,
  input  logic bbutton,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= bbutton;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == stable) begin
        // Any bounce back to the accepted level restarts the qualification.
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
        // Only the accepted press (level going low) is an event.
        press  <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_scheduler.sv
// Arbitrates button presses and heartbeat ticks onto one serial transmitter.
// Latency: tx_start rises 2 cycles after a press/tick pulse when idle.
// Backpressure: tx_start holds until tx_busy; events queue as one pending flag
//               per source, a repeat while pending sets sticky overrun.
// Ports: clk, rst (async active-high), bbutton (raw active-low button),
//        tx_busy (transmitter ack/busy), tx_start, tx_data[7:0],
//        sched_active (not IDLE), overrun (sticky).
module frame_scheduler
  import sched_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES  = 270000,
  parameter int         HEARTBEAT_CYCLES = 27000000,
  parameter int         GAP_CYCLES       = 64,
  parameter logic [3:0] BTN_TAG          = BTN_TAG_DEF,
  parameter logic [3:0] HB_TAG           = HB_TAG_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bbutton,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       sched_active,
  output logic       overrun
);

  localparam int HW = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic             press;
  logic [HW-1:0]    hb_cnt;
  logic             hb_tick;
  logic             btn_pend;
  logic             hb_pend;
  logic             take_btn;
  logic             take_hb;
  state_t           state;
  logic [SEQ_W-1:0] seq;
  logic [GW-1:0]    gap_cnt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .bbutton(bbutton),
    .press  (press)
  );

  // Free-running heartbeat; tick on the terminal count.
  assign hb_tick = (hb_cnt == HW'(HEARTBEAT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_cnt <= '0;
    end else if (hb_tick) begin
      hb_cnt <= '0;
    end else begin
      hb_cnt <= hb_cnt + 1'b1;
    end
  end

  // Fixed priority: button beats heartbeat.
  assign take_btn = (state == IDLE) && btn_pend;
  assign take_hb  = (state == IDLE) && !btn_pend && hb_pend;

  // A new event in the same cycle as the clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_pend <= 1'b0;
      hb_pend  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      btn_pend <= press | (btn_pend & ~take_btn);
      hb_pend  <= hb_tick | (hb_pend & ~take_hb);
      if ((press && btn_pend) || (hb_tick && hb_pend)) begin
        overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      seq          <= '0;
      gap_cnt      <= '0;
      tx_start     <= 1'b0;
      tx_data      <= 8'h00;
      sched_active <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take_btn || take_hb) begin
            state        <= LAUNCH;
            tx_start     <= 1'b1;
            sched_active <= 1'b1;
            tx_data      <= make_frame(take_btn ? BTN_TAG : HB_TAG, seq);
            seq          <= seq + 1'b1;
          end
        end
        LAUNCH: begin
          // Busy already high on entry counts as the ack.
          if (tx_busy) begin
            state    <= SHIFT;
            tx_start <= 1'b0;
          end
        end
        SHIFT: begin
          if (!tx_busy) begin
            state   <= GAP;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            state        <= IDLE;
            sched_active <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          tx_start     <= 1'b0;
          sched_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler with a stub transmitter.
// Latency: stub raises tx_busy 1 cycle after tx_start, holds it hold_len cycles.
// Backpressure: hold_len can be stretched to keep a frame busy.
module tb_frame_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       bbutton;
  logic       tx_busy = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       sched_active;
  logic       overrun;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;
  int hold     = 0;
  int hold_len = 10;

  logic [7:0] frames[$];
  int         starts[$];
  int         gaps[$];
  int         last_fall;
  logic       have_fall = 1'b0;
  logic       prev_start = 1'b0;
  logic       prev_busy = 1'b0;
  logic [7:0] cur_frame = 8'h00;

  frame_scheduler #(
    .DEBOUNCE_CYCLES (4),
    .HEARTBEAT_CYCLES(200),
    .GAP_CYCLES      (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bbutton     (bbutton),
    .tx_busy     (tx_busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .sched_active(sched_active),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stub transmitter.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy <= 1'b0;
      hold    <= 0;
    end else if (hold > 0) begin
      hold <= hold - 1;
      if (hold == 1) tx_busy <= 1'b0;
    end else if (tx_start) begin
      tx_busy <= 1'b1;
      hold    <= hold_len;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame monitor: launches, busy falls, handshake sanity.
  always @(negedge clk) begin
    if (rst) begin
      prev_start = 1'b0;
      prev_busy  = 1'b0;
    end else begin
      if (tx_start && !prev_start) begin
        frames.push_back(tx_data);
        starts.push_back(cyc - t0);
        if (have_fall) gaps.push_back(cyc - t0 - last_fall);
        cur_frame = tx_data;
      end
      if (!tx_start && prev_start) begin
        chk("start_held_until_ack", {31'd0, tx_busy}, 32'd1);
        chk("data_stable", {24'd0, tx_data}, {24'd0, cur_frame});
      end
      if (!tx_busy && prev_busy) begin
        last_fall = cyc - t0;
        have_fall = 1'b1;
      end
      prev_start = tx_start;
      prev_busy  = tx_busy;
    end
  end

  function automatic logic [31:0] get_frame(input int i);
    return (frames.size() > i) ? {24'd0, frames[i]} : 32'hEEEE;
  endfunction

  function automatic logic [31:0] get_start(input int i);
    return (starts.size() > i) ? starts[i] : -1;
  endfunction

  function automatic logic [31:0] get_gap(input int i);
    return (gaps.size() > i) ? gaps[i] : -1;
  endfunction

  task automatic clear_log();
    frames.delete();
    starts.delete();
    gaps.delete();
    have_fall = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst     = 1'b1;
    bbutton = 1'b1;
    repeat (2) @(negedge clk);
    clear_log();
    rst = 1'b0;
    t0  = cyc;
  endtask

  task automatic wait_until(input int rel);
    while ((cyc - t0) < rel) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc_s, acc_a, acc_o;
    logic [7:0] acc_d;
    rst     = 1'b1;
    bbutton = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_active", {31'd0, sched_active}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    clear_log();
    rst = 1'b0;
    t0  = cyc;

    // Quiet period after reset: nothing may move before the first tick.
    acc_s = 1'b0; acc_a = 1'b0; acc_o = 1'b0; acc_d = 8'h00;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      acc_s |= tx_start;
      acc_a |= sched_active;
      acc_o |= overrun;
      acc_d |= tx_data;
    end
    chk("quiet_tx_start", {31'd0, acc_s}, 32'd0);
    chk("quiet_tx_data", {24'd0, acc_d}, 32'd0);
    chk("quiet_active", {31'd0, acc_a}, 32'd0);
    chk("quiet_overrun", {31'd0, acc_o}, 32'd0);

    // Heartbeat only: ticks after P199/P399/P599, launches 2 cycles later.
    wait_until(650);
    chk("hb_count", frames.size(), 3);
    chk("hb_frame0", get_frame(0), 32'h50);
    chk("hb_frame1", get_frame(1), 32'h51);
    chk("hb_frame2", get_frame(2), 32'h52);
    chk("hb_start0", get_start(0), 201);
    chk("hb_start1", get_start(1), 401);

    // Bouncy press: 2-cycle bounces never qualify; final low from P18 gives
    // press after P23, flag P24, launch P25. Release must add nothing.
    apply_reset();
    wait_until(5);
    for (int i = 0; i < 12; i++) begin
      bbutton = ((i / 2) % 2) == 1;
      @(negedge clk);
    end
    bbutton = 1'b0;
    wait_until(60);
    bbutton = 1'b1;
    wait_until(190);
    chk("btn_count", frames.size(), 1);
    chk("btn_frame0", get_frame(0), 32'hB0);
    chk("btn_start0", get_start(0), 25);
    chk("btn_overrun", {31'd0, overrun}, 32'd0);
    chk("btn_idle", {31'd0, sched_active}, 32'd0);

    // Collision: press pulse and tick both after P199, both pending at P201.
    // Heartbeat waits: busy falls P212, GAP P213..P215, launch P216.
    apply_reset();
    wait_until(193);
    bbutton = 1'b0;
    wait_until(230);
    bbutton = 1'b1;
    wait_until(380);
    chk("col_count", frames.size(), 2);
    chk("col_first", get_frame(0), 32'hB0);
    chk("col_second", get_frame(1), 32'h51);
    chk("col_start0", get_start(0), 201);
    chk("col_gap", get_gap(0), 4);

    // Overrun and wrap: first frame busy P202..P652 swallows ticks 399 and 599.
    apply_reset();
    hold_len = 450;
    wait_until(210);
    hold_len = 10;
    wait_until(500);
    chk("ovr_before", {31'd0, overrun}, 32'd0);
    wait_until(620);
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    wait_until(3650);
    chk("wrap_count", frames.size(), 17);
    chk("wrap_start1", get_start(1), 656);
    for (int k = 0; k < 17; k++) begin
      chk($sformatf("wrap_frame%0d", k), get_frame(k), 32'h50 + (k % 16));
    end
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Reset mid-frame: button frame B0 starts at 13, SHIFT from P15.
    apply_reset();
    wait_until(5);
    bbutton = 1'b0;
    wait_until(18);
    chk("mid_frame0", get_frame(0), 32'hB0);
    chk("mid_active", {31'd0, sched_active}, 32'd1);
    chk("mid_busy", {31'd0, tx_busy}, 32'd1);
    rst     = 1'b1;
    bbutton = 1'b1;
    #1;
    chk("mid_rst_start", {31'd0, tx_start}, 32'd0);
    chk("mid_rst_active", {31'd0, sched_active}, 32'd0);
    chk("mid_rst_data", {24'd0, tx_data}, 32'd0);
    chk("mid_rst_overrun", {31'd0, overrun}, 32'd0);
    repeat (2) @(negedge clk);
    clear_log();
    rst = 1'b0;
    t0  = cyc;
    wait_until(210);
    chk("post_count", frames.size(), 1);
    chk("post_frame0", get_frame(0), 32'h50);
    chk("post_start0", get_start(0), 201);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
